// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// datapath mux selects and the packed control word.
package mips_ctrl_pkg;

  localparam int OPW = 6;
  localparam int STW = 4;

  typedef enum logic [STW-1:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ASB_B      = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
interface mips_ctrl_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           pc_write;
  logic           pc_write_cond;
  logic           iord;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           mem_to_reg;
  logic           reg_dst;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic [1:0]     pc_src;
  logic           illegal_op;
  logic [STW-1:0] state_dbg;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, state_dbg
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: maps the current FSM state to the raw control word.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    // NOTE: every field defaults to 0 first so no path through the case infers a latch.
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = ASB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCS_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = ASB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ASB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCS_ALUOUT;
      end
      S_ADDI_WB: ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCS_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS: state register, opcode-driven
// next-state logic and the mem_ready gating of the fetch strobes.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst,
  mips_ctrl_if.master    ctl
);

  state_e     state_q, state_d;
  ctrl_t      raw_ctrl;
  logic       illegal_d;
  logic       fetch_gate;
  logic [5:0] op;

  assign op = 6'(ctl.opcode);

  // NOTE: state uses non-blocking assignment; the async reset drops outputs to 0 without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (ctl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (ctl.mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (ctl.mem_ready) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_RESET;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (raw_ctrl)
  );

  // IR and PC load only in the fetch cycle that actually returns the instruction.
  assign fetch_gate = (state_q == S_FETCH) ? ctl.mem_ready : 1'b1;

  assign ctl.pc_write      = raw_ctrl.pc_write & fetch_gate;
  assign ctl.ir_write      = raw_ctrl.ir_write & fetch_gate;
  assign ctl.pc_write_cond = raw_ctrl.pc_write_cond;
  assign ctl.iord          = raw_ctrl.iord;
  assign ctl.mem_read      = raw_ctrl.mem_read;
  assign ctl.mem_write     = raw_ctrl.mem_write;
  assign ctl.mem_to_reg    = raw_ctrl.mem_to_reg;
  assign ctl.reg_dst       = raw_ctrl.reg_dst;
  assign ctl.reg_write     = raw_ctrl.reg_write;
  assign ctl.alu_src_a     = raw_ctrl.alu_src_a;
  assign ctl.alu_src_b     = raw_ctrl.alu_src_b;
  assign ctl.alu_op        = raw_ctrl.alu_op;
  assign ctl.pc_src        = raw_ctrl.pc_src;
  assign ctl.illegal_op    = illegal_d;
  assign ctl.state_dbg     = STW'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle MIPS control FSM: walks each instruction
// class, memory wait states, an illegal opcode and a mid-instruction reset.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_cnt  = 0;
  int   start;

  always #5 clk = ~clk;

  mips_ctrl_if #(.OPW(6), .STW(4)) bus ();

  mips_multicycle_ctrl #(.OPW(6), .STW(4)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.master)
  );

  localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                 ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_RTEX = 7,
                 ST_RTWB = 8, ST_BRANCH = 9, ST_ADDIEX = 10, ST_ADDIWB = 11,
                 ST_JUMP = 12;

  // Word layout: pcw pcc iord mr mw irw m2r rd rw asa | asb | aop | psrc | ill
  localparam logic [16:0] W_ZERO    = '0;
  localparam logic [16:0] W_F_WAIT  = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_F_GO    = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_DEC     = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_DEC_ILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [16:0] W_MEMADR  = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_MEMRD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_MEMWB   = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_MEMWR   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_RTEX    = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] W_RTWB    = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_BRANCH  = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [16:0] W_ADDIEX  = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_ADDIWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] W_JUMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};

  function automatic logic [16:0] obs_word();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive mem_ready, check state and control word, advance.
  task automatic cyc(input logic rdy, input int st, input logic [16:0] w, input string tag);
    bus.mem_ready = rdy;
    #1;
    check({tag, "_state"}, 32'(bus.state_dbg), 32'(st));
    check({tag, "_ctrl"}, 32'(obs_word()), 32'(w));
    cyc_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'b000000;

    // Reset held: state and all outputs zero, mem_ready ignored.
    #3;
    check("rst_state", 32'(bus.state_dbg), ST_RESET);
    check("rst_ctrl", 32'(obs_word()), 32'(W_ZERO));
    @(posedge clk); #1;
    cyc(1'b1, ST_RESET, W_ZERO, "rst_ready_ignored");
    rst = 1'b0;
    cyc(1'b0, ST_RESET, W_ZERO, "rst_release");

    // beq with two fetch wait cycles: 3 + 2 = 5 cycles.
    bus.opcode = 6'b000100;
    start = cyc_cnt;
    cyc(1'b0, ST_FETCH, W_F_WAIT, "beq_fetch_w1");
    cyc(1'b0, ST_FETCH, W_F_WAIT, "beq_fetch_w2");
    cyc(1'b1, ST_FETCH, W_F_GO, "beq_fetch_go");
    cyc(1'b1, ST_DECODE, W_DEC, "beq_decode");
    cyc(1'b1, ST_BRANCH, W_BRANCH, "beq_branch");
    check("beq_cycles", 32'(cyc_cnt - start), 32'd5);

    // lw, zero wait states: 5 cycles.
    bus.opcode = 6'b100011;
    start = cyc_cnt;
    cyc(1'b1, ST_FETCH, W_F_GO, "lw_fetch");
    cyc(1'b0, ST_DECODE, W_DEC, "lw_decode");
    cyc(1'b0, ST_MEMADR, W_MEMADR, "lw_memadr");
    cyc(1'b1, ST_MEMRD, W_MEMRD, "lw_memrd");
    cyc(1'b1, ST_MEMWB, W_MEMWB, "lw_memwb");
    check("lw_cycles", 32'(cyc_cnt - start), 32'd5);

    // lw with three read wait cycles: 8 cycles, mem_read/iord held 4.
    start = cyc_cnt;
    cyc(1'b1, ST_FETCH, W_F_GO, "lww_fetch");
    cyc(1'b1, ST_DECODE, W_DEC, "lww_decode");
    cyc(1'b1, ST_MEMADR, W_MEMADR, "lww_memadr");
    cyc(1'b0, ST_MEMRD, W_MEMRD, "lww_memrd_w1");
    cyc(1'b0, ST_MEMRD, W_MEMRD, "lww_memrd_w2");
    cyc(1'b0, ST_MEMRD, W_MEMRD, "lww_memrd_w3");
    cyc(1'b1, ST_MEMRD, W_MEMRD, "lww_memrd_go");
    cyc(1'b0, ST_MEMWB, W_MEMWB, "lww_memwb");
    check("lww_cycles", 32'(cyc_cnt - start), 32'd8);

    // sw with one write wait: 4 + 1 = 5 cycles.
    bus.opcode = 6'b101011;
    start = cyc_cnt;
    cyc(1'b1, ST_FETCH, W_F_GO, "sw_fetch");
    cyc(1'b1, ST_DECODE, W_DEC, "sw_decode");
    cyc(1'b1, ST_MEMADR, W_MEMADR, "sw_memadr");
    cyc(1'b0, ST_MEMWR, W_MEMWR, "sw_memwr_w1");
    cyc(1'b1, ST_MEMWR, W_MEMWR, "sw_memwr_go");
    check("sw_cycles", 32'(cyc_cnt - start), 32'd5);

    // R-type: 4 cycles.
    bus.opcode = 6'b000000;
    start = cyc_cnt;
    cyc(1'b1, ST_FETCH, W_F_GO, "rt_fetch");
    cyc(1'b1, ST_DECODE, W_DEC, "rt_decode");
    cyc(1'b1, ST_RTEX, W_RTEX, "rt_ex");
    cyc(1'b1, ST_RTWB, W_RTWB, "rt_wb");
    check("rt_cycles", 32'(cyc_cnt - start), 32'd4);

    // addi: 4 cycles.
    bus.opcode = 6'b001000;
    start = cyc_cnt;
    cyc(1'b1, ST_FETCH, W_F_GO, "addi_fetch");
    cyc(1'b1, ST_DECODE, W_DEC, "addi_decode");
    cyc(1'b1, ST_ADDIEX, W_ADDIEX, "addi_ex");
    cyc(1'b1, ST_ADDIWB, W_ADDIWB, "addi_wb");
    check("addi_cycles", 32'(cyc_cnt - start), 32'd4);

    // j: 3 cycles.
    bus.opcode = 6'b000010;
    start = cyc_cnt;
    cyc(1'b1, ST_FETCH, W_F_GO, "j_fetch");
    cyc(1'b1, ST_DECODE, W_DEC, "j_decode");
    cyc(1'b1, ST_JUMP, W_JUMP, "j_jump");
    check("j_cycles", 32'(cyc_cnt - start), 32'd3);

    // Illegal opcode: one-cycle illegal_op in DECODE, straight back to FETCH.
    bus.opcode = 6'b111111;
    cyc(1'b1, ST_FETCH, W_F_GO, "ill_fetch");
    cyc(1'b1, ST_DECODE, W_DEC_ILL, "ill_decode");
    cyc(1'b0, ST_FETCH, W_F_WAIT, "ill_back_fetch");

    // Reset in the middle of a stalled lw read.
    bus.opcode = 6'b100011;
    cyc(1'b1, ST_FETCH, W_F_GO, "mr_fetch");
    cyc(1'b0, ST_DECODE, W_DEC, "mr_decode");
    cyc(1'b0, ST_MEMADR, W_MEMADR, "mr_memadr");
    bus.mem_ready = 1'b0;
    #1;
    check("mr_memrd_state", 32'(bus.state_dbg), ST_MEMRD);
    rst = 1'b1;
    #1;
    check("mr_async_state", 32'(bus.state_dbg), ST_RESET);
    check("mr_async_ctrl", 32'(obs_word()), 32'(W_ZERO));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, ST_RESET, W_ZERO, "mr_released");
    cyc(1'b0, ST_FETCH, W_F_WAIT, "mr_refetch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
